// File: rtl/pixel_timing_ctrl_pkg.sv
// Shared constants for the pixel timing controller: chip codes, line and frame
// geometry per chip, and named phase indices. Chip code 2'b11 is not a real
// part and falls back to PAL geometry everywhere.
package pixel_timing_ctrl_pkg;

    typedef enum logic [1:0] {
        CHIP_PAL      = 2'b00,
        CHIP_NTSC     = 2'b01,
        CHIP_NTSC_OLD = 2'b10,
        CHIP_RSVD     = 2'b11
    } chip_e;

    localparam logic [6:0] CYCLES_PAL      = 7'd63;
    localparam logic [6:0] CYCLES_NTSC     = 7'd65;
    localparam logic [6:0] CYCLES_NTSC_OLD = 7'd64;

    localparam logic [8:0] LINES_PAL       = 9'd312;
    localparam logic [8:0] LINES_NTSC      = 9'd263;
    localparam logic [8:0] LINES_NTSC_OLD  = 9'd262;

    localparam logic [3:0] PHASE_FIRST     = 4'd0;
    localparam logic [3:0] PHASE_PRE_LAST  = 4'd14;
    localparam logic [3:0] PHASE_LAST      = 4'd15;
    localparam logic [1:0] DOT_LAST        = 2'd3;

    // Index of the final cycle of a line for the given chip.
    function automatic logic [6:0] last_cycle(input chip_e c);
        logic [6:0] n;
        case (c)
            CHIP_NTSC:     n = CYCLES_NTSC;
            CHIP_NTSC_OLD: n = CYCLES_NTSC_OLD;
            default:       n = CYCLES_PAL;
        endcase
        return n - 7'd1;
    endfunction

    // Index of the final raster line of a frame for the given chip.
    function automatic logic [8:0] last_line(input chip_e c);
        logic [8:0] n;
        case (c)
            CHIP_NTSC:     n = LINES_NTSC;
            CHIP_NTSC_OLD: n = LINES_NTSC_OLD;
            default:       n = LINES_PAL;
        endcase
        return n - 9'd1;
    endfunction

endpackage

// File: rtl/pixel_phase_gen.sv
// Purpose: 16-phase counter and the per-phase strobes derived from it.
// Ports: clk_i/rst_i (sync, active-high); phase_o current phase; phi_phase_start_o
//        one-hot phase; dot_rising_o one-hot sub-phase; clk_phi_o; two latch strobes.
// Every output is a register loaded from the next phase, so it matches phase_o exactly.
module pixel_phase_gen
    import pixel_timing_ctrl_pkg::*;
#(
    parameter logic [3:0] PIXEL_LATCH_PHASE   = 4'd14,
    parameter logic [3:0] XSCROLL_LATCH_PHASE = 4'd12
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [3:0]  phase_o,
    output logic [15:0] phi_phase_start_o,
    output logic [3:0]  dot_rising_o,
    output logic        clk_phi_o,
    output logic        pixel_latch_stb_o,
    output logic        xscroll_latch_stb_o
);

    logic [3:0]  phase_q,   phase_d;
    logic [15:0] phi_q,     phi_d;
    logic [3:0]  dot_q,     dot_d;
    logic        clk_phi_q, clk_phi_d;
    logic        pix_q,     pix_d;
    logic        xscr_q,    xscr_d;

    // Decode from the next phase so the registered strobes line up with phase_q.
    always_comb begin
        phase_d   = phase_q + 4'd1;
        phi_d     = 16'd1 << phase_d;
        dot_d     = 4'd1 << phase_d[1:0];
        clk_phi_d = phase_d[3];
        pix_d     = (phase_d == PIXEL_LATCH_PHASE);
        xscr_d    = (phase_d == XSCROLL_LATCH_PHASE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q   <= PHASE_FIRST;
            phi_q     <= 16'h0001;
            dot_q     <= 4'b0001;
            clk_phi_q <= 1'b0;
            pix_q     <= 1'b0;
            xscr_q    <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            phi_q     <= phi_d;
            dot_q     <= dot_d;
            clk_phi_q <= clk_phi_d;
            pix_q     <= pix_d;
            xscr_q    <= xscr_d;
        end
    end

    assign phase_o             = phase_q;
    assign phi_phase_start_o   = phi_q;
    assign dot_rising_o        = dot_q;
    assign clk_phi_o           = clk_phi_q;
    assign pixel_latch_stb_o   = pix_q;
    assign xscroll_latch_stb_o = xscr_q;

endmodule

// File: rtl/pixel_timing_ctrl.sv
// Purpose: master dot-rate timing sequencer (phase strobes, cycle_num, xpos, line wrap).
// Ports: clk_dot4x, rst (sync, active-high), chip select in; phase/dot strobes, latch
//        strobes, cycle_num, xpos, xpos_mod_8, line_wrap_stb out; all outputs registered.
// Optional build macro PIXEL_TIMING_RASTER_EN adds raster_line and frame_wrap_stb.
module pixel_timing_ctrl
    import pixel_timing_ctrl_pkg::*;
#(
    parameter logic [3:0] PIXEL_LATCH_PHASE   = 4'd14,
    parameter logic [3:0] XSCROLL_LATCH_PHASE = 4'd12,
    parameter logic [9:0] XPOS_START          = 10'h194
) (
    input  logic        clk_dot4x,
    input  logic        rst,
    input  logic [1:0]  chip,
    output logic        clk_phi,
    output logic [15:0] phi_phase_start,
    output logic [3:0]  dot_rising,
    output logic        pixel_latch_stb,
    output logic        xscroll_latch_stb,
    output logic [6:0]  cycle_num,
    output logic [9:0]  xpos,
    output logic [2:0]  xpos_mod_8,
`ifdef PIXEL_TIMING_RASTER_EN
    output logic [8:0]  raster_line,
    output logic        frame_wrap_stb,
`endif
    output logic        line_wrap_stb
);

    logic [3:0] phase;

    pixel_phase_gen #(
        .PIXEL_LATCH_PHASE   (PIXEL_LATCH_PHASE),
        .XSCROLL_LATCH_PHASE (XSCROLL_LATCH_PHASE)
    ) u_phase_gen (
        .clk_i               (clk_dot4x),
        .rst_i               (rst),
        .phase_o             (phase),
        .phi_phase_start_o   (phi_phase_start),
        .dot_rising_o        (dot_rising),
        .clk_phi_o           (clk_phi),
        .pixel_latch_stb_o   (pixel_latch_stb),
        .xscroll_latch_stb_o (xscroll_latch_stb)
    );

    chip_e      chip_q,      chip_d;
    logic [6:0] cycle_q,     cycle_d;
    logic [9:0] xpos_q,      xpos_d;
    logic       line_wrap_q, line_wrap_d;
    logic       last_cycle_now;
    logic       wrap_now;

    always_comb begin
        last_cycle_now = (cycle_q == last_cycle(chip_q));
        wrap_now       = (phase == PHASE_LAST) && last_cycle_now;
        cycle_d        = cycle_q;
        xpos_d         = xpos_q;
        chip_d         = chip_q;
        if (wrap_now) begin
            // Chip is only sampled here so a line never changes length midway.
            cycle_d = 7'd0;
            xpos_d  = XPOS_START;
            chip_d  = chip_e'(chip);
        end else begin
            if (phase == PHASE_LAST) begin
                cycle_d = cycle_q + 7'd1;
            end
            if (phase[1:0] == DOT_LAST) begin
                xpos_d = xpos_q + 10'd1;
            end
        end
        // Registered strobe: it must be high while phase 15 of the last cycle is shown,
        // so it is set on the edge leaving phase 14 (cycle cannot change on that edge).
        line_wrap_d = (phase == PHASE_PRE_LAST) && last_cycle_now;
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            chip_q      <= CHIP_PAL;
            cycle_q     <= 7'd0;
            xpos_q      <= XPOS_START;
            line_wrap_q <= 1'b0;
        end else begin
            chip_q      <= chip_d;
            cycle_q     <= cycle_d;
            xpos_q      <= xpos_d;
            line_wrap_q <= line_wrap_d;
        end
    end

    assign cycle_num     = cycle_q;
    assign xpos          = xpos_q;
    assign xpos_mod_8    = xpos_q[2:0];
    assign line_wrap_stb = line_wrap_q;

`ifdef PIXEL_TIMING_RASTER_EN
    logic [8:0] raster_q, raster_d;
    logic       frame_wrap_q, frame_wrap_d;

    always_comb begin
        raster_d = raster_q;
        if (wrap_now) begin
            // >= rather than == keeps the counter bounded if a shorter frame
            // geometry is selected while the raster is past its end.
            raster_d = (raster_q >= last_line(chip_q)) ? 9'd0 : raster_q + 9'd1;
        end
        frame_wrap_d = line_wrap_d && (raster_q >= last_line(chip_q));
    end

    always_ff @(posedge clk_dot4x) begin
        if (rst) begin
            raster_q     <= 9'd0;
            frame_wrap_q <= 1'b0;
        end else begin
            raster_q     <= raster_d;
            frame_wrap_q <= frame_wrap_d;
        end
    end

    assign raster_line    = raster_q;
    assign frame_wrap_stb = frame_wrap_q;
`endif

endmodule
